// File: rtl/voting_ballot_collector.sv
// Ballot collector ahead of the majority voter: gathers one ballot per voter ID,
// drops duplicates and out-of-range IDs, and presents the completed round on valid/ready.
module voting_ballot_collector #(
    parameter int NUM_VOTERS = 7,
    parameter int ID_W       = 3,
    parameter int CNT_W      = 3,
    parameter int THRESH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [ID_W-1:0]       in_id_i,
    input  logic                  in_vote_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [NUM_VOTERS-1:0] out_ballots_o,
    output logic [CNT_W-1:0]      out_yes_count_o,
    output logic                  out_pass_o,
    output logic                  dup_err_o,
    output logic                  id_err_o
);
    localparam int GOT_W = $clog2(NUM_VOTERS + 1);
    localparam logic [ID_W:0]      ID_LIM  = (ID_W + 1)'(NUM_VOTERS);
    localparam logic [GOT_W-1:0]   GOT_END = GOT_W'(NUM_VOTERS - 1);
    localparam logic [CNT_W:0]     THR     = (CNT_W + 1)'(THRESH);

    typedef enum logic {COLLECT, PRESENT} state_e;

    state_e                state_q, state_d;
    logic [NUM_VOTERS-1:0] seen_q, seen_d;
    logic [NUM_VOTERS-1:0] ballots_q, ballots_d;
    logic [CNT_W-1:0]      yes_q, yes_d;
    logic [GOT_W-1:0]      got_q, got_d;
    logic                  dup_q, dup_d;
    logic                  ide_q, ide_d;

    // One-hot decode of the incoming voter ID, one lane per voter.
    logic [NUM_VOTERS-1:0] hit;
    for (genvar i = 0; i < NUM_VOTERS; i++) begin : g_voter
        assign hit[i] = (in_id_i == ID_W'(i));
    end

    logic id_oob, dup;
    assign id_oob = {1'b0, in_id_i} >= ID_LIM;
    assign dup    = |(hit & seen_q);

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        ballots_d = ballots_q;
        yes_d     = yes_q;
        got_d     = got_q;
        dup_d     = 1'b0;
        ide_d     = 1'b0;
        if (flush_i) begin
            seen_d    = '0;
            ballots_d = '0;
            yes_d     = '0;
            got_d     = '0;
            state_d   = COLLECT;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (in_valid_i) begin
                        if (id_oob) begin
                            ide_d = 1'b1;
                        end else if (dup) begin
                            dup_d = 1'b1;
                        end else begin
                            seen_d    = seen_q | hit;
                            ballots_d = ballots_q | (hit & {NUM_VOTERS{in_vote_i}});
                            yes_d     = yes_q + CNT_W'(in_vote_i);
                            got_d     = got_q + GOT_W'(1);
                            if (got_q == GOT_END) state_d = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (out_ready_i) begin
                        seen_d    = '0;
                        ballots_d = '0;
                        yes_d     = '0;
                        got_d     = '0;
                        state_d   = COLLECT;
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= COLLECT;
            seen_q    <= '0;
            ballots_q <= '0;
            yes_q     <= '0;
            got_q     <= '0;
            dup_q     <= 1'b0;
            ide_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            ballots_q <= ballots_d;
            yes_q     <= yes_d;
            got_q     <= got_d;
            dup_q     <= dup_d;
            ide_q     <= ide_d;
        end
    end

    assign in_ready_o      = (state_q == COLLECT);
    assign out_valid_o     = (state_q == PRESENT);
    assign out_ballots_o   = ballots_q;
    assign out_yes_count_o = yes_q;
    assign out_pass_o      = {1'b0, yes_q} >= THR;
    assign dup_err_o       = dup_q;
    assign id_err_o        = ide_q;
endmodule

// File: tb/tb_voting_ballot_collector.sv
// Scoreboard bench: the driver predicts per-cycle outputs and completed rounds from a
// voter-array model; a negedge monitor compares them against the collector.
module tb_voting_ballot_collector;
    localparam int NV = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_vote, flush, out_valid, out_ready;
    logic [2:0] in_id;
    logic [6:0] out_ballots;
    logic [2:0] out_yes_count;
    logic       out_pass, dup_err, id_err;

    always #5 clk = ~clk;

    voting_ballot_collector #(.NUM_VOTERS(7), .ID_W(3), .CNT_W(3), .THRESH(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_id_i(in_id), .in_vote_i(in_vote), .flush_i(flush), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_ballots_o(out_ballots), .out_yes_count_o(out_yes_count),
        .out_pass_o(out_pass), .dup_err_o(dup_err), .id_err_o(id_err)
    );

    typedef struct packed {
        logic rdy; logic vld; logic [6:0] b; logic [2:0] y; logic p; logic d; logic e;
    } snap_t;
    typedef struct packed { logic [6:0] b; logic [2:0] y; logic p; } round_t;

    int     checks = 0, errors = 0, hs_count = 0;
    snap_t  snap_q[$];
    round_t round_q[$];
    bit     mon_en = 1'b0;

    // Reference model: which voters have voted, what they voted, and whether a round is up.
    bit m_voted[NV];
    bit m_vote[NV];
    bit m_pres, m_dup, m_ide;

    function automatic int n_voted();
        int n = 0;
        for (int i = 0; i < NV; i++) n += int'(m_voted[i]);
        return n;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        int yes = 0;
        s.b = '0;
        for (int i = 0; i < NV; i++) begin
            if (m_voted[i] && m_vote[i]) begin
                s.b[i] = 1'b1;
                yes++;
            end
        end
        s.y   = 3'(yes);
        s.p   = (yes >= 4);
        s.rdy = !m_pres;
        s.vld = m_pres;
        s.d   = m_dup;
        s.e   = m_ide;
        return s;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NV; i++) begin
            m_voted[i] = 1'b0;
            m_vote[i]  = 1'b0;
        end
        m_pres = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Apply inputs for the coming edge, queue what is visible now, then advance the model.
    task automatic drive(input bit v, input int id, input bit vote, input bit fl, input bit ordy);
        snap_t s;
        in_valid  = v;
        in_id     = 3'(id);
        in_vote   = vote;
        flush     = fl;
        out_ready = ordy;
        snap_q.push_back(model_snap());
        mon_en = 1'b1;
        if (fl) begin
            if (m_pres && round_q.size() > 0) round_q.delete(round_q.size() - 1);
            model_clear();
            m_dup = 1'b0;
            m_ide = 1'b0;
        end else if (!m_pres) begin
            m_dup = 1'b0;
            m_ide = 1'b0;
            if (v) begin
                if (id >= NV) m_ide = 1'b1;
                else if (m_voted[id]) m_dup = 1'b1;
                else begin
                    m_voted[id] = 1'b1;
                    m_vote[id]  = vote;
                    if (n_voted() == NV) begin
                        m_pres = 1'b1;
                        s = model_snap();
                        round_q.push_back({s.b, s.y, s.p});
                    end
                end
            end
        end else begin
            m_dup = 1'b0;
            m_ide = 1'b0;
            if (ordy) model_clear();
        end
    endtask

    task automatic step(input bit v, input int id, input bit vote, input bit fl, input bit ordy);
        tick();
        drive(v, id, vote, fl, ordy);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {in_ready, out_valid, out_ballots, out_yes_count, out_pass, dup_err, id_err},
            {1'b1, 1'b0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0});
    endtask

    // Called just after a clock edge; verifies outputs fall without waiting for a clock.
    task automatic async_reset(input string nm);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(nm);
        mon_en = 1'b0;
        snap_q.delete();
        round_q.delete();
        model_clear();
        m_dup = 1'b0;
        m_ide = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_id = '0; in_vote = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic full_round(input bit ordy);
        for (int i = 0; i < NV; i++) step(1'b1, i, 1'($urandom_range(0, 1)), 1'b0, ordy);
    endtask

    snap_t  act, exp_s;
    round_t exp_r;
    always @(negedge clk) begin
        if (mon_en && snap_q.size() > 0) begin
            exp_s = snap_q.pop_front();
            act = {in_ready, out_valid, out_ballots, out_yes_count, out_pass, dup_err, id_err};
            checks++;
            if (act !== exp_s) begin
                errors++;
                $display("FAIL cycle_outputs got=%h exp=%h (rdy,vld,ballots,yes,pass,dup,iderr)",
                         act, exp_s);
            end
            if (out_valid && out_ready && !flush) begin
                checks++;
                hs_count++;
                if (round_q.size() == 0) begin
                    errors++;
                    $display("FAIL round_unexpected got=%h exp=none",
                             {out_ballots, out_yes_count, out_pass});
                end else begin
                    exp_r = round_q.pop_front();
                    if ({out_ballots, out_yes_count, out_pass} !== exp_r) begin
                        errors++;
                        $display("FAIL round_result got=%h exp=%h",
                                 {out_ballots, out_yes_count, out_pass}, exp_r);
                    end
                end
            end
        end
    end

    initial begin
        int v1[NV] = '{1, 0, 1, 1, 0, 1, 0};
        int ord[NV] = '{6, 2, 0, 5, 1, 4, 3};
        model_clear();
        m_dup = 1'b0; m_ide = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_id = '0; in_vote = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_values");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // In-order round with a known tally.
        for (int i = 0; i < NV; i++) step(1'b1, i, 1'(v1[i]), 1'b0, 1'b1);
        tick();
        chk("ordered_valid", 32'(out_valid), 32'd1);
        chk("ordered_ballots", 32'(out_ballots), 32'b0101101);
        chk("ordered_yes", 32'(out_yes_count), 32'd4);
        chk("ordered_pass", 32'(out_pass), 32'd1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("ready_after_hs", 32'(in_ready), 32'd1);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Scrambled all-no round with downstream stalled and extra ballots offered.
        for (int i = 0; i < NV; i++) step(1'b1, ord[i], 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, $urandom_range(0, 6), 1'b1, 1'b0, 1'b0);
        tick();
        chk("stall_yes", 32'(out_yes_count), 32'd0);
        chk("stall_pass", 32'(out_pass), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Duplicate ballot for voter 3.
        step(1'b1, 3, 1'b1, 1'b0, 1'b1);
        step(1'b1, 3, 1'b0, 1'b0, 1'b1);
        tick();
        chk("dup_pulse", 32'(dup_err), 32'd1);
        chk("dup_keeps_first", 32'(out_ballots[3]), 32'd1);
        drive(1'b1, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("dup_one_cycle", 32'(dup_err), 32'd0);
        drive(1'b1, 1, 1'b1, 1'b0, 1'b1);
        foreach (ord[i]) if (ord[i] inside {2, 4, 5, 6}) step(1'b1, ord[i], 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Out-of-range voter ID.
        step(1'b1, 7, 1'b1, 1'b0, 1'b1);
        tick();
        chk("id_err_pulse", 32'(id_err), 32'd1);
        chk("id_err_no_change", 32'(out_ballots), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Flush with a ballot in the same cycle after four ballots.
        for (int i = 0; i < 4; i++) step(1'b1, i, 1'b1, 1'b0, 1'b1);
        step(1'b1, 4, 1'b1, 1'b1, 1'b1);
        tick();
        chk("flush_ballots", 32'(out_ballots), 32'd0);
        chk("flush_yes", 32'(out_yes_count), 32'd0);
        drive(1'b0, 0, 1'b0, 1'b0, 1'b1);
        full_round(1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-round and while presenting.
        for (int i = 0; i < 5; i++) step(1'b1, i, 1'b1, 1'b0, 1'b0);
        tick();
        async_reset("reset_mid_round");
        full_round(1'b0);
        tick();
        async_reset("reset_in_present");
        full_round(1'b1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);

        // Randomized traffic.
        repeat (800) step(1'($urandom_range(0, 99) < 70), $urandom_range(0, 7),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) < 3),
                          1'($urandom_range(0, 99) < 60));
        repeat (3) step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("rounds_drained", 32'(round_q.size()), 32'd0);
        chk("enough_rounds", 32'(hs_count >= 8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/voting_ballot_collector.md
# voting_ballot_collector

Sequential ballot-gathering stage that sits directly upstream of the combinational majority voter. It accepts one ballot per handshake from a shared ballot bus and rejects duplicate or out-of-range voter IDs. Once every voter has voted, it presents the complete ballot vector, a running yes-count and a pass/fail decision on a valid/ready output port. After the downstream stage consumes the result, it clears its state and starts a new round.

## Interface
Parameters:
- NUM_VOTERS, default 7: ballots per round; legal range 2..64.
- ID_W, default 3: width of the voter ID; 2^ID_W ≥ NUM_VOTERS.
- CNT_W, default 3: yes-count width; 2^CNT_W ≥ NUM_VOTERS+1.
- THRESH, default 4: pass threshold; the round passes when yes_count ≥ THRESH.

Ports:
- clk, in, 1: the single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- in_valid, in, 1: a ballot is present on in_id/in_vote.
- in_ready, out, 1: the collector can accept a ballot.
- in_id, in, ID_W: ID of the voter casting the ballot.
- in_vote, in, 1: ballot value; 1 = yes.
- flush, in, 1: synchronous abort of the current round.
- out_valid, out, 1: a completed round is presented.
- out_ready, in, 1: the downstream stage accepts the round.
- out_ballots, out, NUM_VOTERS: bit i = vote of voter i.
- out_yes_count, out, CNT_W: number of yes ballots.
- out_pass, out, 1: out_yes_count ≥ THRESH.
- dup_err, out, 1: one-cycle pulse; a duplicate ballot was dropped.
- id_err, out, 1: one-cycle pulse; a ballot with in_id ≥ NUM_VOTERS was dropped.

## Operation
- Two-state FSM: COLLECT and PRESENT. Reset state is COLLECT.
- Registers:
  - seen[NUM_VOTERS-1:0]
  - ballots[NUM_VOTERS-1:0]
  - yes_cnt[CNT_W-1:0]
  - got_cnt, a count of accepted ballots
  - dup_err and id_err flops
- Reset (async, rst_n=0): all registers go to 0; state goes to COLLECT.
- Output values during and after reset, before the first accepted ballot: in_ready=1, out_valid=0, out_ballots=0, out_yes_count=0, out_pass=0 (1 only if THRESH=0), dup_err=0, id_err=0.
- COLLECT:
  - in_ready=1 and out_valid=0.
  - A ballot is accepted on any edge with in_valid=1.
  - If in_id ≥ NUM_VOTERS: the ballot is dropped and id_err=1 for the next cycle.
  - Else if seen[in_id]=1: the ballot is dropped and dup_err=1 for the next cycle. The first vote stands.
  - Otherwise: seen[in_id]←1, ballots[in_id]←in_vote, got_cnt+1, and yes_cnt+in_vote.
  - If this accepted ballot makes got_cnt reach NUM_VOTERS, the state goes to PRESENT on the same edge.
- PRESENT:
  - in_ready=0 and out_valid=1.
  - out_ballots, out_yes_count and out_pass hold stable until the handshake.
  - When out_valid && out_ready: seen, ballots, yes_cnt and got_cnt clear to 0 and the state goes to COLLECT.
- out_ballots and out_yes_count are driven directly from their registers in every state, so the partial tally is visible during COLLECT.
- out_pass is a combinational compare of yes_cnt against THRESH.
- flush=1 clears seen, ballots, yes_cnt and got_cnt and forces COLLECT, from either state. flush has priority over ballot acceptance and over the output handshake. Any ballot offered in a flush cycle is lost.
- Counter widths guarantee no overflow; yes_cnt ≤ got_cnt ≤ NUM_VOTERS.

## Timing
- Ballot to state update: 1 cycle. The accepting edge updates the registers.
- Latency from the final accepted ballot to out_valid: 1 cycle. out_valid rises after the same edge that accepted the final ballot.
- Output handshake to in_ready high: 1 cycle. The next ballot can be accepted on the edge after the handshake edge.
- Throughput: NUM_VOTERS+1 cycles per round minimum, with zero-wait out_ready.
- dup_err and id_err assert for exactly one cycle per offending ballot. Back-to-back offenders produce a continuous high.
- in_valid while in_ready=0 is ignored; the source must hold the ballot until in_ready is high.
- rst_n asserted mid-round or mid-PRESENT: immediate return to reset values. A partially collected round is discarded and no out_valid is produced.

## Test plan
- Reset, then ballots in ID order 0..6 with votes 1,0,1,1,0,1,0 on consecutive cycles, out_ready=1. Required: out_valid=1 one cycle after ID 6, out_ballots=7'b0101101, out_yes_count=4, out_pass=1; in_ready=1 the cycle after the handshake.
- Ballots in scrambled order 6,2,0,5,1,4,3, all votes=0, with out_ready held 0 for 5 cycles. Required: out_valid held for those cycles with outputs stable and in_ready=0; extra ballots offered meanwhile are not accepted; out_yes_count=0 and out_pass=0.
- ID 3 voted yes, then ID 3 voted no. Required: dup_err pulses 1 cycle, ballots[3] stays 1, got_cnt unchanged; the round completes only after all 7 distinct IDs.
- in_id=7 with NUM_VOTERS=7. Required: id_err pulses 1 cycle, no state change.
- After 4 ballots, assert flush with a simultaneous ballot. Required: next cycle out_ballots=0 and out_yes_count=0; a full round of 7 is then needed for out_valid.
- Drop rst_n after 5 ballots, and separately during PRESENT. Required: outputs take their reset values immediately, without waiting for a clock edge; 7 new ballots are needed for the next round.
